// File: rtl/issue_slots.sv
// Issue-queue slot storage: holds waiting micro-ops, tracks operand wakeup,
// raises ready requests to the arbiter and registers the granted entry for issue.
module issue_slots #(
    parameter int SIZE   = 8,
    parameter int TAG_W  = 7,
    parameter int DATA_W = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_alloc_valid,
    input  logic [DATA_W-1:0]         i_alloc_data,
    input  logic [TAG_W-1:0]          i_alloc_rs1,
    input  logic [TAG_W-1:0]          i_alloc_rs2,
    input  logic                      i_alloc_rdy1,
    input  logic                      i_alloc_rdy2,
    output logic                      o_alloc_ready,
    input  logic                      i_wake_valid,
    input  logic [TAG_W-1:0]          i_wake_tag,
    output logic [SIZE-1:0]           o_request,
    input  logic [SIZE-1:0]           i_grant,
    input  logic                      i_issue_en,
    output logic                      o_issue_valid,
    output logic [DATA_W-1:0]         o_issue_data,
    output logic [TAG_W-1:0]          o_issue_rs1,
    output logic [TAG_W-1:0]          o_issue_rs2,
    output logic [$clog2(SIZE+1)-1:0] o_count
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic [SIZE-1:0]   slot_vld_p0;
    logic [SIZE-1:0]   slot_rdy1_p0;
    logic [SIZE-1:0]   slot_rdy2_p0;
    logic [DATA_W-1:0] slot_data_p0 [SIZE];
    logic [TAG_W-1:0]  slot_rs1_p0  [SIZE];
    logic [TAG_W-1:0]  slot_rs2_p0  [SIZE];
    logic [CNT_W-1:0]  count_p0;

    logic              issue_vld_p1;
    logic [DATA_W-1:0] issue_data_p1;
    logic [TAG_W-1:0]  issue_rs1_p1;
    logic [TAG_W-1:0]  issue_rs2_p1;

    logic [SIZE-1:0]   sel;
    logic [SIZE-1:0]   free_mask;
    logic [SIZE-1:0]   alloc_mask;
    logic [SIZE-1:0]   wake1;
    logic [SIZE-1:0]   wake2;
    logic              alloc_fire;
    logic              issue_fire;
    logic              alloc_rdy1;
    logic              alloc_rdy2;
    logic [IDX_W-1:0]  alloc_idx;
    logic [DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]  sel_rs1;
    logic [TAG_W-1:0]  sel_rs2;

    function automatic logic [IDX_W-1:0] first_free(input logic [SIZE-1:0] vld);
        first_free = '0;
        for (int k = SIZE - 1; k >= 0; k--)
            if (!vld[k]) first_free = IDX_W'(k);
    endfunction

    assign o_request     = slot_vld_p0 & slot_rdy1_p0 & slot_rdy2_p0;
    assign o_alloc_ready = ~&slot_vld_p0;
    assign o_count       = count_p0;

    assign sel        = i_grant & o_request;
    assign issue_fire = i_issue_en & (|sel);
    assign free_mask  = i_issue_en ? sel : '0;

    // Slots freed by this cycle's issue still read as valid here, so they are not reused until next cycle.
    assign alloc_fire = i_alloc_valid & o_alloc_ready;
    assign alloc_idx  = first_free(slot_vld_p0);
    assign alloc_mask = alloc_fire ? (SIZE'(1) << alloc_idx) : '0;
    assign alloc_rdy1 = i_alloc_rdy1 | (i_wake_valid & (i_wake_tag == i_alloc_rs1));
    assign alloc_rdy2 = i_alloc_rdy2 | (i_wake_valid & (i_wake_tag == i_alloc_rs2));

    always_comb begin
        sel_data = '0;
        sel_rs1  = '0;
        sel_rs2  = '0;
        wake1    = '0;
        wake2    = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (sel[k]) begin
                sel_data = sel_data | slot_data_p0[k];
                sel_rs1  = sel_rs1 | slot_rs1_p0[k];
                sel_rs2  = sel_rs2 | slot_rs2_p0[k];
            end
            wake1[k] = i_wake_valid & (slot_rs1_p0[k] == i_wake_tag);
            wake2[k] = i_wake_valid & (slot_rs2_p0[k] == i_wake_tag);
        end
    end

    // Slot state (p0) and issue register (p1)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_vld_p0   <= '0;
            slot_rdy1_p0  <= '0;
            slot_rdy2_p0  <= '0;
            count_p0      <= '0;
            issue_vld_p1  <= 1'b0;
            issue_data_p1 <= '0;
            issue_rs1_p1  <= '0;
            issue_rs2_p1  <= '0;
        end else if (i_flush) begin
            slot_vld_p0  <= '0;
            count_p0     <= '0;
            issue_vld_p1 <= 1'b0;
        end else begin
            slot_vld_p0  <= (slot_vld_p0 & ~free_mask) | alloc_mask;
            slot_rdy1_p0 <= ((slot_rdy1_p0 | (slot_vld_p0 & wake1)) & ~alloc_mask)
                          | (alloc_mask & {SIZE{alloc_rdy1}});
            slot_rdy2_p0 <= ((slot_rdy2_p0 | (slot_vld_p0 & wake2)) & ~alloc_mask)
                          | (alloc_mask & {SIZE{alloc_rdy2}});
            if (alloc_fire && !issue_fire)
                count_p0 <= count_p0 + CNT_W'(1);
            else if (!alloc_fire && issue_fire)
                count_p0 <= count_p0 - CNT_W'(1);
            if (i_issue_en) begin
                issue_vld_p1 <= issue_fire;
                if (issue_fire) begin
                    issue_data_p1 <= sel_data;
                    issue_rs1_p1  <= sel_rs1;
                    issue_rs2_p1  <= sel_rs2;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (alloc_fire) begin
            slot_data_p0[alloc_idx] <= i_alloc_data;
            slot_rs1_p0[alloc_idx]  <= i_alloc_rs1;
            slot_rs2_p0[alloc_idx]  <= i_alloc_rs2;
        end
    end

    assign o_issue_valid = issue_vld_p1;
    assign o_issue_data  = issue_data_p1;
    assign o_issue_rs1   = issue_rs1_p1;
    assign o_issue_rs2   = issue_rs2_p1;

    always @(posedge i_clk)
        if (i_rst_n && !i_flush)
            assert ($onehot0(i_grant)) else $error("issue_slots: multi-hot i_grant %b", i_grant);

endmodule
